// File: rtl/multi_channel_timer_if.sv
// multi_channel_timer_if: config/status bundle between the MMU (master) and the timer (slave)
//   cfg_we/cfg_op/cfg_ch       one command per cycle: op 0 = START (load+run), 1 = STOP
//   cfg_load_val/periodic/presc START arguments: ticks to expiry, reload mode, prescaler compare
//   irq_clr                    write-1-to-clear for expired[]
//   rd_ch / rd_count           combinational count readback
//   timer_is_high/expired/expire_pulse/irq_o  per-channel status and summary interrupt
interface multi_channel_timer_if #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8,
   parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic                cfg_we;
   logic                cfg_op;
   logic [CH_W-1:0]     cfg_ch;
   logic [CNT_W-1:0]    cfg_load_val;
   logic                cfg_periodic;
   logic [PRESC_W-1:0]  cfg_presc;
   logic [NUM_CH-1:0]   irq_clr;
   logic [CH_W-1:0]     rd_ch;
   logic [NUM_CH-1:0]   timer_is_high;
   logic [NUM_CH-1:0]   expired;
   logic [NUM_CH-1:0]   expire_pulse;
   logic                irq_o;
   logic [CNT_W-1:0]    rd_count;
   modport master (
      output cfg_we, cfg_op, cfg_ch, cfg_load_val, cfg_periodic, cfg_presc, irq_clr, rd_ch,
      input  timer_is_high, expired, expire_pulse, irq_o, rd_count
   );
   modport slave (
      input  cfg_we, cfg_op, cfg_ch, cfg_load_val, cfg_periodic, cfg_presc, irq_clr, rd_ch,
      output timer_is_high, expired, expire_pulse, irq_o, rd_count
   );
endinterface

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: N-channel prescaled down-counting timer with one-shot/periodic modes
//   clk  system clock, all state on rising edge
//   rst  synchronous active-low reset
//   bus  multi_channel_timer_if.slave: config commands in, status/readback out
module multi_channel_timer #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input logic                clk,
   input logic                rst,
   multi_channel_timer_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t                          r_state [NUM_CH];
   state_t                          w_state_n [NUM_CH];
   logic [NUM_CH-1:0][CNT_W-1:0]    r_count, w_count_n, r_load, w_load_n;
   logic [NUM_CH-1:0][PRESC_W-1:0]  r_pcnt, w_pcnt_n, r_presc, w_presc_n;
   logic [NUM_CH-1:0]               r_periodic, w_periodic_n, r_expired, w_expired_n;
   logic [NUM_CH-1:0]               r_pulse, w_fire, w_high, w_start, w_stop;
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) r_state[i] <= IDLE;
         r_count    <= '0;
         r_load     <= '0;
         r_pcnt     <= '0;
         r_presc    <= '0;
         r_periodic <= '0;
         r_expired  <= '0;
         r_pulse    <= '0;
      end else begin
         r_state    <= w_state_n;
         r_count    <= w_count_n;
         r_load     <= w_load_n;
         r_pcnt     <= w_pcnt_n;
         r_presc    <= w_presc_n;
         r_periodic <= w_periodic_n;
         r_expired  <= w_expired_n;
         r_pulse    <= w_fire;
      end
   end
   // Priority per channel: START (restart) > STOP > tick. A command on a channel
   // therefore suppresses any expiry that channel would have produced this cycle.
   always_comb begin
      w_state_n    = r_state;
      w_count_n    = r_count;
      w_load_n     = r_load;
      w_pcnt_n     = r_pcnt;
      w_presc_n    = r_presc;
      w_periodic_n = r_periodic;
      w_expired_n  = r_expired;
      w_fire       = '0;
      w_high       = '0;
      w_start      = '0;
      w_stop       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_high[i]  = r_state[i] == RUN;
         w_start[i] = bus.cfg_we && !bus.cfg_op && int'(bus.cfg_ch) == i;
         w_stop[i]  = bus.cfg_we && bus.cfg_op && int'(bus.cfg_ch) == i;
         if (w_start[i]) begin
            w_load_n[i]     = bus.cfg_load_val;
            w_periodic_n[i] = bus.cfg_periodic;
            w_presc_n[i]    = bus.cfg_presc;
            w_pcnt_n[i]     = '0;
            w_count_n[i]    = bus.cfg_load_val;
            // A zero load expires immediately and never enters RUN
            w_state_n[i]    = bus.cfg_load_val == '0 ? IDLE : RUN;
            w_fire[i]       = bus.cfg_load_val == '0;
         end else if (w_stop[i] && w_high[i]) begin
            w_state_n[i] = IDLE;
            w_count_n[i] = '0;
            w_pcnt_n[i]  = '0;
         end else if (w_high[i] && r_pcnt[i] == r_presc[i]) begin
            w_pcnt_n[i]  = '0;
            w_fire[i]    = r_count[i] == CNT_W'(1);
            w_count_n[i] = w_fire[i] ? (r_periodic[i] ? r_load[i] : '0) : r_count[i] - 1'b1;
            w_state_n[i] = w_fire[i] && !r_periodic[i] ? IDLE : RUN;
         end else if (w_high[i]) begin
            w_pcnt_n[i] = r_pcnt[i] + 1'b1;
         end
         // Same-cycle expiry beats irq_clr
         w_expired_n[i] = (r_expired[i] & ~bus.irq_clr[i]) | w_fire[i];
      end
   end
   assign bus.timer_is_high = w_high;
   assign bus.expired       = r_expired;
   assign bus.expire_pulse  = r_pulse;
   assign bus.irq_o         = |r_expired;
   assign bus.rd_count      = int'(bus.rd_ch) < NUM_CH ? r_count[bus.rd_ch] : '0;
endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer: directed + random stimulus against a deadline-based reference model
module tb_multi_channel_timer;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 32;
   localparam int PRESC_W = 8;
   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;
   always #5 clk = ~clk;
   multi_channel_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();
   multi_channel_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );
   // Model: each running channel holds the number of clock cycles left until its
   // expiry edge; the visible count is that remainder in whole tick periods.
   bit                m_run [NUM_CH];
   bit                m_periodic [NUM_CH];
   longint            m_rem [NUM_CH];
   longint            m_period [NUM_CH];
   longint            m_div [NUM_CH];
   logic [NUM_CH-1:0] m_exp, m_pulse;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   function automatic longint m_count(input int ch);
      return m_run[ch] ? (m_rem[ch] + m_div[ch] - 1) / m_div[ch] : 0;
   endfunction
   task automatic model_step();
      logic fire;
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 0;
            m_rem[i] = 0;
            m_div[i] = 1;
         end
         m_exp   = '0;
         m_pulse = '0;
         return;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         fire = 1'b0;
         if (bus.cfg_we && int'(bus.cfg_ch) == i && !bus.cfg_op) begin
            m_div[i]      = longint'(bus.cfg_presc) + 1;
            m_period[i]   = longint'(bus.cfg_load_val) * m_div[i];
            m_periodic[i] = bus.cfg_periodic;
            m_run[i]      = bus.cfg_load_val != 0;
            m_rem[i]      = m_period[i];
            fire          = bus.cfg_load_val == 0;
         end else if (bus.cfg_we && int'(bus.cfg_ch) == i && bus.cfg_op) begin
            m_run[i] = 0;
         end else if (m_run[i]) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               fire = 1'b1;
               if (m_periodic[i]) m_rem[i] = m_period[i];
               else m_run[i] = 0;
            end
         end
         m_exp[i]   = (m_exp[i] & ~bus.irq_clr[i]) | fire;
         m_pulse[i] = fire;
      end
   endtask
   task automatic verify();
      logic [NUM_CH-1:0] hi;
      for (int i = 0; i < NUM_CH; i++) hi[i] = m_run[i];
      check("timer_is_high", 64'(bus.timer_is_high), 64'(hi));
      check("expired", 64'(bus.expired), 64'(m_exp));
      check("expire_pulse", 64'(bus.expire_pulse), 64'(m_pulse));
      check("irq_o", 64'(bus.irq_o), 64'(|m_exp));
      check("rd_count", 64'(bus.rd_count), 64'(m_count(int'(bus.rd_ch))));
   endtask
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      verify();
      bus.cfg_we  = 1'b0;
      bus.irq_clr = '0;
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask
   task automatic cmd(input logic op, input int ch, input int n, input logic per, input int presc);
      bus.cfg_we       = 1'b1;
      bus.cfg_op       = op;
      bus.cfg_ch       = 2'(ch);
      bus.cfg_load_val = CNT_W'(n);
      bus.cfg_periodic = per;
      bus.cfg_presc    = PRESC_W'(presc);
      step();
   endtask
   initial begin
      rst = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_op = 1'b0; bus.cfg_ch = '0; bus.cfg_load_val = '0;
      bus.cfg_periodic = 1'b0; bus.cfg_presc = '0; bus.irq_clr = '0; bus.rd_ch = '0;
      idle(2);
      rst = 1'b1;
      idle(1);
      cmd(1'b0, 0, 5, 1'b0, 0);
      idle(7);
      check("t1_expired0", 64'(bus.expired[0]), 64'd1);
      check("t1_irq", 64'(bus.irq_o), 64'd1);
      bus.rd_ch = 2'd1;
      cmd(1'b0, 1, 3, 1'b1, 2);
      idle(30);
      cmd(1'b1, 1, 0, 1'b0, 0);
      bus.rd_ch = 2'd2;
      cmd(1'b0, 2, 10, 1'b0, 0);
      idle(3);
      cmd(1'b1, 2, 0, 1'b0, 0);
      check("t3_stop_high", 64'(bus.timer_is_high[2]), 64'd0);
      check("t3_stop_exp", 64'(bus.expired[2]), 64'd0);
      cmd(1'b0, 2, 2, 1'b0, 0);
      idle(1);
      cmd(1'b1, 2, 0, 1'b0, 0);
      check("t3_race_pulse", 64'(bus.expire_pulse[2]), 64'd0);
      bus.rd_ch = 2'd3;
      bus.irq_clr = 4'b1000;
      cmd(1'b0, 3, 0, 1'b1, 0);
      check("t4_expired3", 64'(bus.expired[3]), 64'd1);
      check("t4_high3", 64'(bus.timer_is_high[3]), 64'd0);
      bus.irq_clr = 4'b1111;
      idle(2);
      bus.rd_ch = 2'd0;
      cmd(1'b0, 0, 8, 1'b0, 0);
      idle(2);
      cmd(1'b0, 0, 4, 1'b0, 0);
      idle(6);
      bus.rd_ch = 2'd2;
      cmd(1'b0, 2, 2, 1'b0, 255);
      idle(515);
      for (int c = 0; c < NUM_CH; c++) cmd(1'b0, c, 20, 1'(c & 1), c);
      idle(3);
      rst = 1'b0;
      step();
      check("t6_rst_high", 64'(bus.timer_is_high), 64'd0);
      rst = 1'b1;
      idle(90);
      for (int k = 0; k < 4000; k++) begin
         rst              = $urandom_range(0, 399) != 0;
         bus.cfg_we       = $urandom_range(0, 3) == 0;
         bus.cfg_op       = $urandom_range(0, 2) == 0;
         bus.cfg_ch       = 2'($urandom_range(0, NUM_CH - 1));
         bus.cfg_load_val = CNT_W'($urandom_range(0, 9));
         bus.cfg_periodic = 1'($urandom_range(0, 1));
         bus.cfg_presc    = PRESC_W'($urandom_range(0, 3));
         bus.irq_clr      = $urandom_range(0, 7) == 0 ? 4'($urandom) : '0;
         bus.rd_ch        = 2'($urandom_range(0, NUM_CH - 1));
         step();
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
